// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// transmit-FIFO controller state encoding.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } txf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: circular storage with write/read pointers and a
// registered fill count. Full/empty are decoded from the registered count, so a
// write presented while full is refused even if a pop happens in that cycle.
// Reusable by both UART directions.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_count
);

    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;

    assign o_full    = (r_cnt == C_DEPTH);
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_rd_data = r_mem[r_rp];

    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    // Storage array is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    // Fill count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer in front of the UART transmitter. Producers push bytes
// freely; bytes are released one at a time whenever the transmitter is idle.
// Dropped writes (FIFO full) set a sticky overflow flag.
//
// Optional build macro UART_TX_FIFO_LEVEL_EN adds the `level` output (fill count).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for data and an idle transmitter; pops on entry exit
// START     | byte latched in tx_data; act is registered high next cycle
// WAIT_BUSY | waiting for the transmitter to acknowledge with busy high
// WAIT_DONE | transmitter shifting; waiting for busy to fall
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [DATA_W-1:0] tx_data,
    output logic              act,
    input  logic              busy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [AW:0]       level
`endif
);

    txf_state_t        r_state;
    txf_state_t        w_next_state;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_act;
    logic              r_overflow;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign act      = r_act;

`ifdef UART_TX_FIFO_LEVEL_EN
    assign level = w_count;
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and pop request.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !busy) begin
                    w_pop        = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output byte changes only when a byte is popped, so it stays stable
    // for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= '0;
        end else if (w_pop) begin
            r_tx_data <= w_rd_data;
        end
    end

    // Start strobe registered from the START state: a single clean cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act <= 1'b0;
        end else begin
            r_act <= (r_state == START);
        end
    end

    // Sticky overflow: any write attempted while full was dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
